song_sequencer: RTL and testbench
=================================

# song_sequencer

Playback controller that drives the song-progression display and the tone generator. It walks a synchronous note ROM, times each note in divided ticks, and owns the `play`, `song_done` and `reset_player` strobes that the progress-bar block consumes. Sits between the user-button debouncers and both the audio path and the VGA overlay.

## Interface
- `TICK_DIV`, 100000: clk cycles per duration tick (1 ms at 100 MHz).
- `ADDR_W`, 8: note ROM address width.
- `PITCH_W`, 7: pitch code width; 0 = rest.
- `DUR_W`, 8: note duration width, in ticks; duration 0 = end-of-song marker.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start_pause`  in  1  one-cycle pulse; toggles play/pause.
- `restart`  in  1  one-cycle pulse; return to note 0.
- `note_addr`  out  ADDR_W  ROM address.
- `note_data`  in  PITCH_W+DUR_W  {pitch, duration}; valid 1 cycle after `note_addr`.
- `pitch`  out  PITCH_W  current pitch; 0 when not playing.
- `note_on`  out  1  high while a non-rest note sounds.
- `play`  out  1  high in PLAYING.
- `song_done`  out  1  high in DONE.
- `reset_player`  out  1  one-cycle pulse on restart or reset release.

## Operation
- States: IDLE, FETCH, WAIT_ROM, PLAYING, PAUSED, DONE.
- IDLE: addr=0. `start_pause` -> FETCH.
- FETCH: drive `note_addr`; -> WAIT_ROM next cycle.
- WAIT_ROM: latch `note_data`. Duration 0 -> DONE; otherwise load dur counter, -> PLAYING.
- PLAYING: tick divider runs; each tick decrements dur counter. On the tick that makes the counter reach 0: addr+1, -> FETCH. `start_pause` -> PAUSED. Both the divider count and the dur counter are frozen while paused.
- PAUSED: `start_pause` -> PLAYING, resuming the frozen counters.
- DONE: `song_done`=1, `pitch`=0. `start_pause` ignored.
- `restart` in any state: addr=0, divider=0, `reset_player` pulses next cycle, -> IDLE. `restart` has priority over a simultaneous `start_pause`.
- Address wrap: addr incrementing past 2^ADDR_W-1 -> DONE. A ROM without an end marker must never loop.
- `pitch`/`note_on` are registered. They are valid only in PLAYING. They read 0 in FETCH and WAIT_ROM.

## Timing
- Reset values: `note_addr`=0, `pitch`=0, `note_on`=0, `play`=0, `song_done`=0, `reset_player`=0, state=IDLE.
- On the first clk after `rst` deasserts, `reset_player` pulses for 1 cycle.
- Note sounding time = duration × TICK_DIV cycles.
- Inter-note gap (FETCH + WAIT_ROM) = 2 cycles with `play`=1 and `note_on`=0.
- `play` rises 3 cycles after the `start_pause` pulse from IDLE.
- Pause/resume: effective on the cycle after the pulse. No tick is lost or duplicated.

## Configuration
- `SONG_SEQ_LOOP_EN` defined: DONE lasts 1 cycle. Then `reset_player` pulses, addr=0, -> FETCH (auto-replay). `song_done` is still a 1-cycle pulse.
- Not defined: DONE holds until `restart` or reset.

## Structure
- Package `song_pkg` holds:
  - the state enum `seq_state_t`;
  - the `{pitch, duration}` note struct;
  - the default width constants.
- Sub-module `tick_divider`: counter with TICK_DIV period, enable and clear, and a 1-cycle `tick` output.

## Test plan
Bench uses TICK_DIV=4 and a ROM of {60,3},{0 rest,2},{64,1},{x,0}.
- Reset release -> `reset_player` pulses once; all other outputs 0.
- `start_pause` -> `play` rises at +3 cycles. pitch=60 and `note_on`=1 for 12 cycles. 2-cycle gap follows. Rest lasts 8 cycles with `note_on`=0. pitch=64 lasts 4 cycles. `song_done`=1 and `play`=0 afterwards.
- Pause at cycle 5 of note 60, hold 20 cycles, resume -> note 60 still totals exactly 12 active cycles.
- `restart` and `start_pause` in the same cycle mid-note -> IDLE, addr=0, `reset_player` pulses once, `play`=0.
- ROM of 256 nonzero durations with ADDR_W=8 -> DONE after the last note, with no wrap to address 0.
- With `SONG_SEQ_LOOP_EN` -> `song_done` pulses 1 cycle, `reset_player` pulses, and pitch=60 replays.

Source files
------------

// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
// Module      : song_pkg
// Description : Shared types and default widths for the song sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package song_pkg;

    localparam int DEF_TICK_DIV = 100000;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_PITCH_W  = 7;
    localparam int DEF_DUR_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_ROM = 3'd2,
        ST_PLAYING  = 3'd3,
        ST_PAUSED   = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_t;

    // Layout of one note ROM word at the default widths: pitch 0 is a rest,
    // duration 0 marks the end of the song.
    typedef struct packed {
        logic [DEF_PITCH_W-1:0] pitch;
        logic [DEF_DUR_W-1:0]   dur;
    } note_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running modulo-TICK_DIV counter with enable and clear;
//               emits a one-cycle tick on the last count of each period.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider
    import song_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : song_sequencer
// Description : Walks a synchronous note ROM, times each note in divided
//               ticks and drives play / song_done / reset_player strobes.
//               Define SONG_SEQ_LOOP_EN to auto-replay after the end marker.
// Revision    : 1.0 - initial release
// ============================================================================
module song_sequencer
    import song_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PITCH_W  = DEF_PITCH_W,
    parameter int DUR_W    = DEF_DUR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_pause,
    input  logic                     restart,
    output logic [ADDR_W-1:0]        note_addr,
    input  logic [PITCH_W+DUR_W-1:0] note_data,
    output logic [PITCH_W-1:0]       pitch,
    output logic                     note_on,
    output logic                     play,
    output logic                     song_done,
    output logic                     reset_player
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [PITCH_W-1:0] cur_pitch_q, cur_pitch_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic               note_on_q, note_on_d;
    logic               play_q, play_d;
    logic               song_done_q, song_done_d;
    logic               reset_player_q, reset_player_d;
    logic               rst_seen_q, rst_seen_d;

    logic               div_en;
    logic               div_clr;
    logic               tick;
    logic [PITCH_W-1:0] rom_pitch;
    logic [DUR_W-1:0]   rom_dur;

    assign rom_pitch = note_data[PITCH_W+DUR_W-1:DUR_W];
    assign rom_dur   = note_data[DUR_W-1:0];

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        dur_d          = dur_q;
        cur_pitch_d    = cur_pitch_q;
        rst_seen_d     = 1'b1;
        reset_player_d = ~rst_seen_q;
        div_en         = (state_q == ST_PLAYING);
        // Divider phase survives only a pause; every new note starts at zero.
        div_clr        = (state_q != ST_PLAYING) && (state_q != ST_PAUSED);

        if (restart) begin
            state_d        = ST_IDLE;
            addr_d         = '0;
            dur_d          = '0;
            reset_player_d = 1'b1;
            div_clr        = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = '0;
                    if (start_pause) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_WAIT_ROM;
                end
                ST_WAIT_ROM: begin
                    cur_pitch_d = rom_pitch;
                    dur_d       = rom_dur;
                    state_d     = (rom_dur == '0) ? ST_DONE : ST_PLAYING;
                end
                ST_PLAYING: begin
                    if (tick) begin
                        dur_d = dur_q - 1'b1;
                    end
                    if (tick && (dur_q == DUR_W'(1))) begin
                        if (addr_q == ADDR_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            // A pause landing on the final tick resumes straight into the fetch.
                            state_d = start_pause ? ST_PAUSED : ST_FETCH;
                        end
                    end else if (start_pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start_pause) begin
                        state_d = (dur_q == '0) ? ST_FETCH : ST_PLAYING;
                    end
                end
                ST_DONE: begin
`ifdef SONG_SEQ_LOOP_EN
                    state_d        = ST_FETCH;
                    addr_d         = '0;
                    reset_player_d = 1'b1;
`else
                    state_d        = ST_DONE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
            endcase
        end

        pitch_d     = (state_d == ST_PLAYING) ? cur_pitch_d : '0;
        note_on_d   = (state_d == ST_PLAYING) && (cur_pitch_d != '0);
        // play only bridges the inter-note gap once a note has actually sounded.
        play_d      = (state_d == ST_PLAYING) ||
                      (play_q && ((state_d == ST_FETCH) || (state_d == ST_WAIT_ROM)));
        song_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            dur_q          <= '0;
            cur_pitch_q    <= '0;
            pitch_q        <= '0;
            note_on_q      <= 1'b0;
            play_q         <= 1'b0;
            song_done_q    <= 1'b0;
            reset_player_q <= 1'b0;
            rst_seen_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            dur_q          <= dur_d;
            cur_pitch_q    <= cur_pitch_d;
            pitch_q        <= pitch_d;
            note_on_q      <= note_on_d;
            play_q         <= play_d;
            song_done_q    <= song_done_d;
            reset_player_q <= reset_player_d;
            rst_seen_q     <= rst_seen_d;
        end
    end

    assign note_addr    = addr_q;
    assign pitch        = pitch_q;
    assign note_on      = note_on_q;
    assign play         = play_q;
    assign song_done    = song_done_q;
    assign reset_player = reset_player_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_sequencer
// Description : Self-checking bench: a song-level timeline model predicts the
//               per-cycle outputs for directed and random ROMs and pauses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

    localparam int TICK = 4;
    localparam int AW   = 8;
    localparam int PW   = 7;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_pause = 1'b0;
    logic          restart = 1'b0;
    logic [AW-1:0] note_addr;
    logic [PW+DW-1:0] note_data;
    logic [PW-1:0] pitch;
    logic          note_on;
    logic          play;
    logic          song_done;
    logic          reset_player;

    logic [PW-1:0] rom_pitch [256];
    logic [DW-1:0] rom_dur   [256];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic          pl;
        logic          dn;
        logic          rp;
        logic          on;
        logic [PW-1:0] p;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   pausable;
    } rec_t;

    rec_t exp_q[$];

    song_sequencer #(
        .TICK_DIV (TICK),
        .ADDR_W   (AW),
        .PITCH_W  (PW),
        .DUR_W    (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_pause  (start_pause),
        .restart      (restart),
        .note_addr    (note_addr),
        .note_data    (note_data),
        .pitch        (pitch),
        .note_on      (note_on),
        .play         (play),
        .song_done    (song_done),
        .reset_player (reset_player)
    );

    always #5 clk = ~clk;

    always @(posedge clk) note_data <= {rom_pitch[note_addr], rom_dur[note_addr]};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(bit pl, bit dn, bit rp, bit on, logic [PW-1:0] p);
        obs_t o;
        o = {pl, dn, rp, on, p};
        return o;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = {play, song_done, reset_player, note_on, pitch};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed play/done/rp/on/pitch=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                   tag, got.pl, got.dn, got.rp, got.on, got.p, exp.pl, exp.dn, exp.rp, exp.on, exp.p);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic push(input obs_t o, input bit pz);
        rec_t r;
        r.o        = o;
        r.pausable = pz;
        exp_q.push_back(r);
    endtask

    // One pass through the song: 2-cycle fetch gap before every note (silent
    // play on the very first one), dur*TICK sounding cycles, then DONE.
    task automatic add_song(input bit rp_first);
        bit first;
        int len;
        first = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push(mk(!first, 1'b0, first && rp_first, 1'b0, '0), 1'b0);
            push(mk(!first, 1'b0, 1'b0, 1'b0, '0), 1'b0);
            if (rom_dur[i] == '0) begin
                push(mk(1'b0, 1'b1, 1'b0, 1'b0, '0), 1'b0);
                return;
            end
            len = int'(rom_dur[i]) * TICK;
            for (int k = 0; k < len; k++) begin
                push(mk(1'b1, 1'b0, 1'b0, rom_pitch[i] != '0, rom_pitch[i]), k < len - 1);
            end
            first = 1'b0;
        end
        push(mk(1'b0, 1'b1, 1'b0, 1'b0, '0), 1'b0);
    endtask

    task automatic build_timeline();
        exp_q.delete();
        add_song(1'b0);
`ifdef SONG_SEQ_LOOP_EN
        add_song(1'b1);
`else
        for (int i = 0; i < 6; i++) push(mk(1'b0, 1'b1, 1'b0, 1'b0, '0), 1'b0);
`endif
    endtask

    task automatic run_song(input int pause_at, input int pause_len, input int pct, input int abort_at);
        int   idx;
        int   hold;
        rec_t r;
        idx = 0;
        start_pause = 1'b1;
        while (exp_q.size() > 0) begin
            step();
            start_pause = 1'b0;
            r = exp_q.pop_front();
            check("timeline", r.o);
            if (idx == abort_at) begin
                restart     = 1'b1;
                start_pause = 1'b1;
                step();
                restart     = 1'b0;
                start_pause = 1'b0;
                check("restart_pulse", mk(1'b0, 1'b0, 1'b1, 1'b0, '0));
                check_bit("restart_addr0", note_addr == '0, 1'b1);
                step();
                check("restart_idle", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
                step();
                check("restart_idle2", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
                exp_q.delete();
                return;
            end
            if (r.pausable && (idx == pause_at || $urandom_range(0, 99) < pct)) begin
                hold = (idx == pause_at) ? pause_len : int'($urandom_range(1, 20));
                start_pause = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    step();
                    start_pause = 1'b0;
                    check("paused", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
                end
                start_pause = 1'b1;
            end
            idx++;
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_pulse", mk(1'b0, 1'b0, 1'b1, 1'b0, '0));
        check_bit("restart_addr0", note_addr == '0, 1'b1);
        step();
        check("restart_idle", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
    endtask

    task automatic load_directed();
        for (int i = 0; i < 256; i++) begin
            rom_pitch[i] = '0;
            rom_dur[i]   = '0;
        end
        rom_pitch[0] = 7'd60; rom_dur[0] = 8'd3;
        rom_pitch[1] = 7'd0;  rom_dur[1] = 8'd2;
        rom_pitch[2] = 7'd64; rom_dur[2] = 8'd1;
        rom_pitch[3] = 7'd99; rom_dur[3] = 8'd0;
    endtask

    initial begin
        int n;
        load_directed();

        step();
        check("in_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
        check_bit("in_reset_addr0", note_addr == '0, 1'b1);
        step();
        rst = 1'b1;
        step();
        check("reset_release_pulse", mk(1'b0, 1'b0, 1'b1, 1'b0, '0));
        step();
        check("after_release", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
        step();
        check("idle_hold", mk(1'b0, 1'b0, 1'b0, 1'b0, '0));

        build_timeline();
        run_song(-1, 0, 0, -1);
        do_restart();

        build_timeline();
        run_song(6, 20, 0, -1);
        do_restart();

        build_timeline();
        run_song(-1, 0, 0, 8);

        for (int s = 0; s < 5; s++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < 256; i++) begin
                rom_pitch[i] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                rom_dur[i]   = (i < n) ? 8'($urandom_range(1, 4)) : 8'd0;
            end
            build_timeline();
            run_song(-1, 0, 30, -1);
            do_restart();
        end

        for (int i = 0; i < 256; i++) begin
            rom_pitch[i] = 7'($urandom_range(0, 127));
            rom_dur[i]   = 8'd1;
        end
        build_timeline();
        run_song(-1, 0, 0, -1);
`ifndef SONG_SEQ_LOOP_EN
        check_bit("no_wrap_addr", note_addr != '0, 1'b1);
`endif
        do_restart();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
